// File: rtl/riscv_pkg.sv
// Shared types and constants for the reduced RISC-V core.
// Fetch FSM encoding and datapath widths live here.
package riscv_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;
    localparam int PC_INC  = 4;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_WAIT,
        FETCH_HOLD
    } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry instruction FIFO holding {instr, pc} pairs.
// Flush empties the queue; head outputs read zero when empty.
module fetch_buffer #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic               i_flush,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [ADDR_W-1:0]  i_pc,
    output logic               o_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_pc,
    output logic [1:0]         o_count
);

    logic [INSTR_W-1:0] r_instr [2];
    logic [ADDR_W-1:0]  r_pc    [2];
    logic               r_rd_ptr;
    logic               r_wr_ptr;
    logic [1:0]         r_count;

    logic w_push;
    logic w_pop;

    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_instr[i] <= '0;
                r_pc[i]    <= '0;
            end
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_instr[r_wr_ptr] <= i_instr;
                r_pc[r_wr_ptr]    <= i_pc;
                r_wr_ptr          <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign o_instr = o_valid ? r_instr[r_rd_ptr] : '0;
    assign o_pc    = o_valid ? r_pc[r_rd_ptr] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, keeps one memory request
// in flight and feeds decode from a 2-entry buffer, flushing on branches.
module fetch_unit #(
    parameter int          ADDR_W   = 32,
    parameter int          INSTR_W  = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               PCsrc,
    input  logic [ADDR_W-1:0]  ImmOp
);

    import riscv_pkg::*;

    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] INC    = ADDR_W'(PC_INC);

    fetch_state_t r_state;
    fetch_state_t w_next;

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] r_fetched_pc;
    logic [ADDR_W-1:0] w_fpc_next;
    logic [ADDR_W-1:0] w_sum;
    logic [ADDR_W-1:0] w_target;

    logic       r_outstanding;
    logic       w_out_next;
    logic       r_discard;
    logic       w_disc_next;
    logic       w_pop;
    logic       w_redirect;
    logic       w_rsp;
    logic       w_req_hs;
    logic       w_push;
    logic       w_flush;
    logic [1:0] w_count;
    logic [1:0] w_count_after;

    assign w_pop      = instr_valid && instr_ready;
    assign w_redirect = w_pop && PCsrc;
    assign w_sum      = instr_pc + ImmOp;
    assign w_target   = {w_sum[ADDR_W-1:2], 2'b00};
    assign w_rsp      = imem_rsp_valid && r_outstanding;
    assign w_req_hs   = (r_state == FETCH_REQ) && imem_req_ready;

    assign imem_req_valid = (r_state == FETCH_REQ);
    assign imem_addr      = imem_req_valid ? r_pc : '0;

    always_comb begin
        w_next        = r_state;
        w_pc_next     = r_pc;
        w_fpc_next    = r_fetched_pc;
        w_out_next    = r_outstanding;
        w_disc_next   = r_discard;
        w_push        = 1'b0;
        w_flush       = 1'b0;
        w_count_after = w_count - {1'b0, w_pop};
        unique case (r_state)
            FETCH_IDLE: begin
                w_next = FETCH_REQ;
            end
            FETCH_REQ: begin
                if (w_req_hs) begin
                    w_out_next = 1'b1;
                    w_fpc_next = r_pc;
                    w_pc_next  = r_pc + INC;
                    w_next     = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (w_rsp) begin
                    w_out_next = 1'b0;
                    if (r_discard) begin
                        w_disc_next = 1'b0;
                    end else begin
                        w_push        = 1'b1;
                        w_count_after = w_count_after + 2'd1;
                    end
                    w_next = (w_count_after < 2'd2) ? FETCH_REQ : FETCH_HOLD;
                end
            end
            FETCH_HOLD: begin
                if (w_pop) begin
                    w_next = FETCH_REQ;
                end
            end
        endcase
        // A redirect overrides everything; a response landing now is dropped.
        if (w_redirect) begin
            w_pc_next   = w_target;
            w_flush     = 1'b1;
            w_push      = 1'b0;
            w_disc_next = w_out_next;
            w_next      = w_out_next ? FETCH_WAIT : FETCH_REQ;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= FETCH_IDLE;
            r_pc          <= RST_PC;
            r_fetched_pc  <= '0;
            r_outstanding <= 1'b0;
            r_discard     <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_pc          <= w_pc_next;
            r_fetched_pc  <= w_fpc_next;
            r_outstanding <= w_out_next;
            r_discard     <= w_disc_next;
        end
    end

    fetch_buffer #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_instr (imem_rsp_data),
        .i_pc    (r_fetched_pc),
        .o_valid (instr_valid),
        .o_instr (instr),
        .o_pc    (instr_pc),
        .o_count (w_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run checked
// against the architectural program-order stream of fetched instructions.
module tb_fetch_unit;

    import riscv_pkg::*;

    localparam logic [31:0] RPC  = 32'h0000_0000;
    localparam logic [31:0] RPC2 = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        PCsrc = 1'b0;
    logic [31:0] ImmOp = '0;

    logic        rv2;
    logic [31:0] addr2;
    logic        rsp_v2 = 1'b0;
    logic        iv2;
    logic [31:0] instr2;
    logic [31:0] ipc2;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc),
        .PCsrc(PCsrc), .ImmOp(ImmOp)
    );

    fetch_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(RPC2)) dut2 (
        .clk(clk), .rst(rst),
        .imem_req_valid(rv2), .imem_req_ready(1'b1),
        .imem_addr(addr2),
        .imem_rsp_valid(rsp_v2), .imem_rsp_data(NOP_INSTR),
        .instr_valid(iv2), .instr_ready(1'b1),
        .instr(instr2), .instr_pc(ipc2),
        .PCsrc(1'b0), .ImmOp(32'h0)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
    endfunction

    // knobs for directed mode
    logic        rnd = 1'b0;
    logic        knob_req_ready = 1'b1;
    int          knob_lat = 0;
    logic        knob_dec_ready = 1'b1;
    logic [31:0] knob_br_pc = 32'hFFFF_FFFF;
    logic [31:0] knob_imm = '0;
    logic        force_rsp = 1'b0;

    // memory model and expectation state
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int          pend_lat = 0;
    logic        pend2 = 1'b0;
    logic        h_valid = 1'b0;
    logic [31:0] h_addr = '0;
    logic [31:0] exp_pc = RPC;
    logic        exp_known = 1'b1;
    logic [31:0] hs_log[$];
    logic [31:0] pop_log[$];
    logic [31:0] log2[$];
    logic        seen2 = 1'b0;
    logic [31:0] first_ipc2 = '0;
    logic [31:0] first_instr2 = '0;

    int          cyc = 0;
    int          cyc0 = 0;
    int          first_rv = -1;
    int          first_iv = -1;

    logic        s_rv;
    logic [31:0] s_addr;
    logic        s_iv;
    logic [31:0] s_ipc;
    logic [31:0] s_instr;

    task automatic step();
        logic [31:0] tgt;
        logic [31:0] imm;
        logic [31:0] r;
        logic        br;
        logic        s_rv2;
        @(posedge clk);
        #1;
        cyc++;
        s_rv    = imem_req_valid;
        s_addr  = imem_addr;
        s_iv    = instr_valid;
        s_ipc   = instr_pc;
        s_instr = instr;
        s_rv2   = rv2;
        if (s_rv && first_rv < 0) first_rv = cyc;
        if (s_iv && first_iv < 0) first_iv = cyc;
        if (iv2 && !seen2) begin
            seen2        = 1'b1;
            first_ipc2   = ipc2;
            first_instr2 = instr2;
        end
        if (h_valid) begin
            check("req_hold_valid", 32'(s_rv), 32'd1);
            check("req_hold_addr", s_addr, h_addr);
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (pend) begin
            if (pend_lat == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = memf(pend_addr);
                pend           = 1'b0;
            end else begin
                pend_lat--;
            end
        end else if (force_rsp || (rnd && $urandom_range(0, 7) == 0)) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hDEAD_BEEF;
            force_rsp      = 1'b0;
        end
        imem_req_ready = rnd ? 1'($urandom_range(0, 1)) : knob_req_ready;
        if (s_rv && imem_req_ready) begin
            check("one_outstanding", 32'(pend), 32'd0);
            pend      = 1'b1;
            pend_addr = s_addr;
            pend_lat  = rnd ? int'($urandom_range(0, 2)) : knob_lat;
            hs_log.push_back(s_addr);
        end
        instr_ready = rnd ? ($urandom_range(0, 3) != 0) : knob_dec_ready;
        PCsrc = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        ImmOp = $urandom;
        tgt = '0;
        br  = 1'b0;
        if (s_iv && instr_ready) begin
            if (exp_known) check("instr_pc", s_ipc, exp_pc);
            check("instr_data", s_instr, memf(s_ipc));
            if (rnd) begin
                r   = $urandom;
                br  = ($urandom_range(0, 4) == 0);
                imm = {{20{r[11]}}, r[11:0]};
            end else begin
                br  = (s_ipc == knob_br_pc);
                imm = knob_imm;
            end
            PCsrc     = br;
            ImmOp     = imm;
            tgt       = (s_ipc + imm) & 32'hFFFF_FFFC;
            exp_pc    = br ? tgt : s_ipc + 32'd4;
            exp_known = 1'b1;
            pop_log.push_back(s_ipc);
        end
        h_valid = s_rv && !imem_req_ready;
        h_addr  = br ? tgt : s_addr;
        rsp_v2  = pend2;
        pend2   = s_rv2;
        if (s_rv2) log2.push_back(addr2);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        pend      = 1'b0;
        pend2     = 1'b0;
        rsp_v2    = 1'b0;
        h_valid   = 1'b0;
        force_rsp = 1'b0;
        exp_pc    = RPC;
        exp_known = 1'b1;
        seen2     = 1'b0;
        first_rv  = -1;
        first_iv  = -1;
        hs_log.delete();
        pop_log.delete();
        log2.delete();
        step();
        step();
        rst  = 1'b0;
        cyc0 = cyc;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        // basic streaming, wrap on second instance
        do_reset();
        for (int k = 0; k < 40 && pop_log.size() < 3; k++) step();
        check("first_req_latency", 32'(first_rv - cyc0), 32'd1);
        check("first_instr_latency", 32'(first_iv - cyc0), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t1_addr%0d", i), qat(hs_log, i), 32'(4 * i));
            check($sformatf("t1_pc%0d", i), qat(pop_log, i), 32'(4 * i));
        end
        check("wrap_addr0", qat(log2, 0), RPC2);
        check("wrap_addr1", qat(log2, 1), 32'h0000_0000);
        check("wrap_first_pc", first_ipc2, RPC2);
        check("wrap_first_instr", first_instr2, NOP_INSTR);

        // decode stall fills the buffer
        do_reset();
        knob_dec_ready = 1'b0;
        repeat (10) step();
        check("hold_count", 32'(dut.w_count), 32'd2);
        check("hold_state", 32'(dut.r_state == FETCH_HOLD), 32'd1);
        check("hold_req_valid", 32'(s_rv), 32'd0);
        check("hold_reqs", 32'(hs_log.size()), 32'd2);
        check("hold_head_pc", s_ipc, 32'h0);
        knob_dec_ready = 1'b1;
        for (int k = 0; k < 40 && (pop_log.size() < 2 || hs_log.size() < 3); k++) step();
        check("hold_pop0", qat(pop_log, 0), 32'h0);
        check("hold_pop1", qat(pop_log, 1), 32'h4);
        check("hold_next_req", qat(hs_log, 2), 32'h8);

        // backward branch while the next fetch is in flight
        do_reset();
        knob_lat   = 2;
        knob_br_pc = 32'h10;
        knob_imm   = 32'hFFFF_FFF8;
        for (int k = 0; k < 200 && pop_log.size() < 6; k++) step();
        check("br_pop_src", qat(pop_log, 4), 32'h10);
        check("br_pop_tgt", qat(pop_log, 5), 32'h08);
        check("br_inflight", qat(hs_log, 5), 32'h14);
        check("br_refetch", qat(hs_log, 6), 32'h08);
        knob_br_pc = 32'hFFFF_FFFF;

        // request stall, then redirect during the stall
        do_reset();
        knob_lat       = 0;
        knob_dec_ready = 1'b0;
        knob_req_ready = 1'b1;
        for (int k = 0; k < 20 && hs_log.size() < 1; k++) step();
        knob_req_ready = 1'b0;
        repeat (6) step();
        check("stall_valid", 32'(s_rv), 32'd1);
        check("stall_addr", s_addr, 32'h4);
        check("stall_head", 32'(s_iv), 32'd1);
        knob_dec_ready = 1'b1;
        knob_br_pc     = 32'h0;
        knob_imm       = 32'h40;
        step();
        step();
        check("stall_redirect_valid", 32'(s_rv), 32'd1);
        check("stall_redirect_addr", s_addr, 32'h40);
        knob_req_ready = 1'b1;
        knob_br_pc     = 32'hFFFF_FFFF;
        for (int k = 0; k < 40 && pop_log.size() < 2; k++) step();
        check("stall_pop_tgt", qat(pop_log, 1), 32'h40);

        // reset while a response is pending, stale response afterwards
        do_reset();
        knob_lat = 3;
        for (int k = 0; k < 20 && !pend; k++) step();
        check("mid_pending", 32'(pend), 32'd1);
        do_reset();
        force_rsp = 1'b1;
        for (int k = 0; k < 40 && pop_log.size() < 1; k++) step();
        check("mid_first_pc", qat(pop_log, 0), RPC);

        // randomized traffic
        knob_lat = 0;
        do_reset();
        rnd = 1'b1;
        repeat (4000) step();
        rnd = 1'b0;
        check("random_progress", 32'(pop_log.size() > 300), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
